// File: rtl/sig_mem_writer.sv
// Producer side of the shared signal RAM: ECG/EMG samples into circular sweep buffers.
// Define SIG_AUTOSCALE_EN to enable per-sweep min/max tracking and scale-word publishing.
module sig_mem_writer #(
    parameter logic [11:0] ECG_BASE  = 12'h559,
    parameter logic [11:0] EMG_BASE  = 12'h6AD,
    parameter logic [11:0] STAT_BASE = 12'd1705,
    parameter int          SWEEP_LEN = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ecg_valid,
    input  logic [11:0] ecg_data,
    output logic        ecg_ready,
    input  logic        emg_valid,
    input  logic [11:0] emg_data,
    output logic        emg_ready,
    output logic        mem_wEn,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [1:0]  sweep_done
);

    localparam int            IW       = $clog2(SWEEP_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(SWEEP_LEN - 1);

`ifdef SIG_AUTOSCALE_EN
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_STATS} state_t;
`else
    typedef enum logic [1:0] {S_INIT, S_IDLE} state_t;
`endif

    state_t        state, state_nx;
    logic [1:0]    cnt, cnt_nx;
    logic          rdy, rdy_nx;
    logic          wen, wen_nx;
    logic [11:0]   addr, addr_nx;
    logic [11:0]   data, data_nx;
    logic [1:0]    sweep, sweep_nx;
    logic [IW-1:0] ecg_idx, ecg_idx_nx, emg_idx, emg_idx_nx;

    logic          ecg_acc, emg_acc, take, ch, wrap;
    logic [11:0]   smp;
    logic [IW-1:0] idx_cur;

`ifdef SIG_AUTOSCALE_EN
    logic [11:0] ecg_min, ecg_min_nx, ecg_max, ecg_max_nx;
    logic [11:0] emg_min, emg_min_nx, emg_max, emg_max_nx;
    logic [11:0] pub_min, pub_min_nx, pub_max, pub_max_nx;
    logic        pub_ch, pub_ch_nx;
    logic [11:0] new_min, new_max;

    function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [11:0] max12(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? a : b;
    endfunction

    // Published range must be non-empty so the display never divides by zero.
    function automatic logic [11:0] guard_lo(input logic [11:0] lo);
        return (lo == 12'hFFF) ? 12'hFFE : lo;
    endfunction

    function automatic logic [11:0] guard_hi(input logic [11:0] lo, input logic [11:0] hi);
        if (lo == 12'hFFF) return 12'hFFF;
        return (hi <= lo) ? lo + 12'd1 : hi;
    endfunction
`endif

    assign ecg_acc   = (state == S_IDLE) && rdy && ecg_valid;
    assign emg_acc   = (state == S_IDLE) && rdy && emg_valid && !ecg_valid;
    assign take      = ecg_acc || emg_acc;
    assign ch        = !ecg_acc;
    assign smp       = ch ? emg_data : ecg_data;
    assign idx_cur   = ch ? emg_idx : ecg_idx;
    assign wrap      = (idx_cur == IDX_LAST);

    assign ecg_ready  = rdy;
    assign emg_ready  = rdy && !ecg_valid;
    assign mem_wEn    = wen;
    assign mem_addr   = addr;
    assign mem_data   = {20'b0, data};
    assign sweep_done = sweep;

`ifdef SIG_AUTOSCALE_EN
    assign new_min = min12(ch ? emg_min : ecg_min, smp);
    assign new_max = max12(ch ? emg_max : ecg_max, smp);
`endif

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rdy_nx     = rdy;
        wen_nx     = 1'b0;
        addr_nx    = addr;
        data_nx    = data;
        sweep_nx   = 2'b00;
        ecg_idx_nx = ecg_idx;
        emg_idx_nx = emg_idx;
`ifdef SIG_AUTOSCALE_EN
        ecg_min_nx = ecg_min;
        ecg_max_nx = ecg_max;
        emg_min_nx = emg_min;
        emg_max_nx = emg_max;
        pub_min_nx = pub_min;
        pub_max_nx = pub_max;
        pub_ch_nx  = pub_ch;
`endif
        case (state)
            S_INIT: begin
                wen_nx  = 1'b1;
                addr_nx = STAT_BASE + 12'(cnt);
                data_nx = cnt[1] ? 12'hFFF : 12'h000;
                cnt_nx  = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 2'd0;
                    rdy_nx   = 1'b1;
                end
            end
            S_IDLE: begin
                if (take) begin
                    wen_nx  = 1'b1;
                    addr_nx = (ch ? EMG_BASE : ECG_BASE) + 12'(idx_cur);
                    data_nx = smp;
                    if (ch) emg_idx_nx = wrap ? '0 : idx_cur + 1'b1;
                    else    ecg_idx_nx = wrap ? '0 : idx_cur + 1'b1;
                    sweep_nx[ch] = wrap;
`ifdef SIG_AUTOSCALE_EN
                    if (wrap) begin
                        pub_min_nx = guard_lo(new_min);
                        pub_max_nx = guard_hi(new_min, new_max);
                        pub_ch_nx  = ch;
                        state_nx   = S_STATS;
                        cnt_nx     = 2'd0;
                        rdy_nx     = 1'b0;
                    end
                    if (ch) begin
                        emg_min_nx = wrap ? 12'hFFF : new_min;
                        emg_max_nx = wrap ? 12'h000 : new_max;
                    end else begin
                        ecg_min_nx = wrap ? 12'hFFF : new_min;
                        ecg_max_nx = wrap ? 12'h000 : new_max;
                    end
`endif
                end
            end
`ifdef SIG_AUTOSCALE_EN
            S_STATS: begin
                wen_nx = 1'b1;
                if (cnt == 2'd0) begin
                    addr_nx = STAT_BASE + {11'b0, pub_ch};
                    data_nx = pub_min;
                    cnt_nx  = 2'd1;
                end else begin
                    addr_nx  = STAT_BASE + 12'd2 + {11'b0, pub_ch};
                    data_nx  = pub_max;
                    cnt_nx   = 2'd0;
                    state_nx = S_IDLE;
                    rdy_nx   = 1'b1;
                end
            end
`endif
            default: begin
                state_nx = S_INIT;
                cnt_nx   = 2'd0;
                rdy_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_INIT;
            cnt     <= 2'd0;
            rdy     <= 1'b0;
            wen     <= 1'b0;
            addr    <= 12'd0;
            data    <= 12'd0;
            sweep   <= 2'b00;
            ecg_idx <= '0;
            emg_idx <= '0;
`ifdef SIG_AUTOSCALE_EN
            ecg_min <= 12'hFFF;
            ecg_max <= 12'h000;
            emg_min <= 12'hFFF;
            emg_max <= 12'h000;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rdy     <= rdy_nx;
            wen     <= wen_nx;
            addr    <= addr_nx;
            data    <= data_nx;
            sweep   <= sweep_nx;
            ecg_idx <= ecg_idx_nx;
            emg_idx <= emg_idx_nx;
`ifdef SIG_AUTOSCALE_EN
            ecg_min <= ecg_min_nx;
            ecg_max <= ecg_max_nx;
            emg_min <= emg_min_nx;
            emg_max <= emg_max_nx;
`endif
        end
    end

`ifdef SIG_AUTOSCALE_EN
    // Latched stats are only consumed in STATS, which reset always leaves.
    always_ff @(posedge clock) begin
        pub_min <= pub_min_nx;
        pub_max <= pub_max_nx;
        pub_ch  <= pub_ch_nx;
    end
`endif

endmodule

// File: doc/sig_mem_writer.md
Name: sig_mem_writer

Overview:
- Producer side of the shared signal RAM that the VGA display reads for its ECG/EMG traces.
- Accepts 12-bit ECG and EMG samples through valid/ready handshakes and writes them into per-channel 320-entry circular sweep buffers.
- Keeps per-sweep min/max per channel and publishes them to the four scale words the display preloads.
- Drives the RAM write port directly, at most one write per cycle.

Parameters:
- ECG_BASE, 12'h559, first word of the ECG sweep buffer.
- EMG_BASE, 12'h6AD, first word of the EMG sweep buffer.
- STAT_BASE, 12'd1705, scale words in order min_ecg, min_emg, max_ecg, max_emg (STAT_BASE+0..+3).
- SWEEP_LEN, 320, samples per channel per sweep.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- ecg_valid  in  1  ECG sample offered.
- ecg_data  in  12  ECG sample.
- ecg_ready  out  1  ECG sample accepted when valid&&ready.
- emg_valid  in  1  EMG sample offered.
- emg_data  in  12  EMG sample.
- emg_ready  out  1  EMG sample accepted when valid&&ready.
- mem_wEn  out  1  RAM write enable.
- mem_addr  out  12  RAM write address.
- mem_data  out  32  RAM write data; bits [31:12] always 0.
- sweep_done  out  2  one-cycle pulse; bit0 = ECG sweep wrapped, bit1 = EMG sweep wrapped.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port `clock`, reset port `reset`).
- Reset values: mem_wEn=0, mem_addr=0, mem_data=0, ecg_ready=0, emg_ready=0, sweep_done=0; both indices=0; min accumulators=4095, max accumulators=0; FSM=INIT, init counter=0.
- FSM states:
  - INIT: 4 cycles, writes 0, 0, 4095, 4095 to STAT_BASE+0..3 (mem_wEn=1 each cycle), then IDLE.
  - IDLE: ecg_ready=1 always. emg_ready=!ecg_valid, so ECG has fixed priority.
  - STATS: 2 cycles. Writes the wrapped channel's min (STAT_BASE+0 for ECG, +1 for EMG), then its max (+2 / +3). Returns to IDLE. Both readys are 0.
- Readys are registered outputs, driven 1 only in IDLE. The readys fall in the same cycle an accept that triggers a wrap is seen, so there is no accept while in STATS.
- Sample accept in IDLE, cycle N. Cycle N+1 drives mem_wEn=1, mem_addr=BASE+idx, mem_data={20'b0, sample}. Write latency is 1 cycle.
- On accept: idx increments and the accumulators update (min=min(min,s), max=max(max,s)).
- Wrap (accept with idx==SWEEP_LEN-1):
  - idx returns to 0.
  - The final min/max, including this sample, latches into stat registers.
  - Accumulators reset to 4095/0.
  - The sweep_done bit pulses in cycle N+1.
  - FSM enters STATS after the sample write: sample write in N+1, stat writes in N+2 and N+3.
- Zero-range guard: if latched max==min, publish max=min+1. If min==4095, publish min=4094, max=4095. Published max is always greater than min, so the display never divides by zero.
- Simultaneous ECG and EMG valid: ECG is taken, EMG waits. EMG is accepted on the next IDLE cycle with no ECG valid.
- Reset mid-INIT or mid-STATS: the sequence is abandoned, mem_wEn=0 next cycle, FSM restarts at INIT. Partial sweeps are discarded (indices=0).
- RAM contents are not cleared by this block.

Optional Feature:
- SIG_AUTOSCALE_EN defined: behaviour as above.
- SIG_AUTOSCALE_EN undefined:
  - No min/max tracking and no STATS state.
  - Stat words are written only in INIT (0, 0, 4095, 4095).
  - On wrap, FSM stays in IDLE and readys stay 1 (sustained 1 sample/cycle).
  - sweep_done still pulses.

Test Plan:
- Reset release → 4 consecutive writes: (1705,0), (1706,0), (1707,4095), (1708,4095); then ecg_ready=1, emg_ready=1.
- Single ECG sample 0x123 at idx 0 → next cycle mem_wEn=1, addr 0x559, data 0x00000123.
- ECG and EMG valid together with values 5 and 9 → ECG written to 0x559 first; EMG written to 0x6AD one accept later; emg_ready=0 while ecg_valid=1.
- 320 ECG samples with values 100..419 → last sample written at 0x698; sweep_done[0] pulse; writes (1705,100), (1707,419); readys 0 for 2 cycles.
- 320 EMG samples all 4095 → writes (1706,4094), (1708,4095). Repeat with all 7 → (1706,7), (1708,8).
- Reset asserted in the 1st STATS cycle → no max write; INIT sequence replays; next ECG sample lands at 0x559.
